e_muldiv: RTL and testbench

- Iterative multiply/divide unit in the execute stage, alongside the single-cycle ALU.
- Handles the MIPS HI/LO class: mult, multu, div, divu, mthi, mtlo.
- Owns the HI/LO architectural registers and drives a busy signal so the hazard unit stalls mfhi/mflo and new mul/div ops until the result is committed.

---
 rtl/muldiv_pkg.sv | 24 ++
 rtl/e_muldiv_negate.sv | 13 +
 rtl/e_muldiv.sv | 168 ++++++++++++++++
 tb/tb_e_muldiv.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types for the HI/LO multiply/divide unit.
// Op codes, FSM states and the iterative step count.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } muldiv_state_t;

  localparam int MULDIV_STEPS = 32;

endpackage

// File: rtl/e_muldiv_negate.sv
// Conditional two's-complement negate.
// Used for operand magnitudes and result sign fix-up.
module e_muldiv_negate #(
  parameter int W = 32
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);

  assign res = neg ? (~val + W'(1)) : val;

endmodule

// File: rtl/e_muldiv.sv
// Iterative HI/LO multiply/divide unit (execute stage).
// MULDIV_FAST_MUL_EN: single-cycle native multiply for MULT/MULTU.
module e_muldiv
  import muldiv_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_con_Start,
  input  logic [2:0]        i_con_Op,
  input  logic [DATA_W-1:0] i_data_A,
  input  logic [DATA_W-1:0] i_data_B,
  input  logic              i_con_Flush,
  output logic [DATA_W-1:0] o_data_Hi,
  output logic [DATA_W-1:0] o_data_Lo,
  output logic              o_con_Busy,
  output logic              o_con_Done
);

  localparam int CW = $clog2(MULDIV_STEPS);
  localparam int W2 = 2 * DATA_W;

  muldiv_state_t state, state_n;
  muldiv_op_t    op;

  logic              go, is_mul, is_div, sgn, dz;
  logic              last, ge;
  logic [CW-1:0]     cnt;
  logic              mul_q, neg_res, neg_rem;
  logic [DATA_W-1:0] opnd, mag_a, mag_b, quo, rem;
  logic [W2-1:0]     w, w_n, prod;
  logic [DATA_W:0]   sum, rem_sh;

  assign op     = muldiv_op_t'(i_con_Op);
  assign go     = i_con_Start & ~i_con_Flush;
  assign is_mul = (op == OP_MULT) | (op == OP_MULTU);
  assign is_div = (op == OP_DIV) | (op == OP_DIVU);
  assign sgn    = (op == OP_MULT) | (op == OP_DIV);
  assign dz     = is_div & (i_data_B == '0);

  assign o_con_Busy = (state != S_IDLE);

  // Divide by zero keeps the raw dividend so HI ends up equal to A.
  e_muldiv_negate #(.W(DATA_W)) u_neg_a (
    .val (i_data_A),
    .neg (sgn & i_data_A[DATA_W-1] & ~dz),
    .res (mag_a)
  );

  e_muldiv_negate #(.W(DATA_W)) u_neg_b (
    .val (i_data_B),
    .neg (sgn & i_data_B[DATA_W-1]),
    .res (mag_b)
  );

  e_muldiv_negate #(.W(W2)) u_neg_p (
    .val (w),
    .neg (neg_res),
    .res (prod)
  );

  e_muldiv_negate #(.W(DATA_W)) u_neg_q (
    .val (w[DATA_W-1:0]),
    .neg (neg_res),
    .res (quo)
  );

  e_muldiv_negate #(.W(DATA_W)) u_neg_r (
    .val (w[W2-1:DATA_W]),
    .neg (neg_rem),
    .res (rem)
  );

  // One radix-2 step: shift-add multiply or restoring divide.
  always_comb begin
    sum    = {1'b0, w[W2-1:DATA_W]}
           + {1'b0, opnd & {DATA_W{w[0]}}};
    rem_sh = w[W2-1:DATA_W-1];
    ge     = (rem_sh >= {1'b0, opnd});
    last   = (cnt == CW'(MULDIV_STEPS - 1));
    if (mul_q) begin
      w_n = {sum, w[DATA_W-1:1]};
    end else begin
      w_n = {ge ? (rem_sh[DATA_W-1:0] - opnd)
                : rem_sh[DATA_W-1:0],
             w[DATA_W-2:0], ge};
    end
`ifdef MULDIV_FAST_MUL_EN
    if (mul_q) begin
      w_n  = {{DATA_W{1'b0}}, opnd}
           * {{DATA_W{1'b0}}, w[DATA_W-1:0]};
      last = 1'b1;
    end
`endif
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_n;
  end

  // Next state; flush aborts any in-flight op.
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: if (go & (is_mul | is_div)) state_n = S_CALC;
      S_CALC: begin
        if (i_con_Flush) state_n = S_IDLE;
        else if (last)   state_n = S_FIX;
      end
      S_FIX:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Operand latch, iteration and HI/LO commit.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_data_Hi  <= '0;
      o_data_Lo  <= '0;
      o_con_Done <= 1'b0;
      cnt        <= '0;
      w          <= '0;
      opnd       <= '0;
      mul_q      <= 1'b0;
      neg_res    <= 1'b0;
      neg_rem    <= 1'b0;
    end else begin
      o_con_Done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (go & (op == OP_MTHI)) o_data_Hi <= i_data_A;
          if (go & (op == OP_MTLO)) o_data_Lo <= i_data_A;
          if (go & (is_mul | is_div)) begin
            mul_q   <= is_mul;
            opnd    <= is_mul ? mag_a : mag_b;
            w       <= {{DATA_W{1'b0}}, is_mul ? mag_b : mag_a};
            cnt     <= '0;
            neg_res <= sgn & ~dz
                     & (i_data_A[DATA_W-1] ^ i_data_B[DATA_W-1]);
            neg_rem <= sgn & ~dz & is_div & i_data_A[DATA_W-1];
          end
        end
        S_CALC: begin
          if (!i_con_Flush) begin
            w   <= w_n;
            cnt <= cnt + CW'(1);
          end
        end
        S_FIX: begin
          if (!i_con_Flush) begin
            o_con_Done <= 1'b1;
            if (mul_q) begin
              {o_data_Hi, o_data_Lo} <= prod;
            end else begin
              o_data_Hi <= rem;
              o_data_Lo <= quo;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_e_muldiv.sv
// Self-checking bench for e_muldiv.
// Directed plan cases plus random ops against an arithmetic model.
module tb_e_muldiv;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        flush;
  logic [31:0] hi, lo;
  logic        busy, done;

  int checks   = 0;
  int failures = 0;

  logic [31:0] hi_m, lo_m;

  e_muldiv #(.DATA_W(32)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_con_Start (start),
    .i_con_Op    (op),
    .i_data_A    (a),
    .i_data_B    (b),
    .i_con_Flush (flush),
    .o_data_Hi   (hi),
    .o_data_Lo   (lo),
    .o_con_Busy  (busy),
    .o_con_Done  (done)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // {HI, LO} straight from the arithmetic definition of each op.
  function automatic logic [63:0] model(logic [2:0] o,
                                        logic [31:0] x,
                                        logic [31:0] y);
    longint sx, sy;
    logic [63:0] r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    r  = 64'h0;
    case (o)
      OP_MULT:  r = 64'(sx * sy);
      OP_MULTU: r = {32'h0, x} * {32'h0, y};
      OP_DIV: begin
        if (y == 0) r = {x, 32'hFFFF_FFFF};
        else        r = {32'(sx % sy), 32'(sx / sy)};
      end
      OP_DIVU: begin
        if (y == 0) r = {x, 32'hFFFF_FFFF};
        else        r = {x % y, x / y};
      end
      default: r = 64'h0;
    endcase
    return r;
  endfunction

  task automatic run_op(logic [2:0] o, logic [31:0] x,
                        logic [31:0] y, string tag);
    logic [63:0] exp;
    int j, lat;
    exp = model(o, x, y);
    lat = 33;
`ifdef MULDIV_FAST_MUL_EN
    if (o == OP_MULT || o == OP_MULTU) lat = 2;
`endif
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = OP_NONE;
    chk({tag, " busy_on"}, 64'(busy), 64'd1);
    j = 0;
    while (!done && j < 100) begin
      @(negedge clk);
      j++;
    end
    chk({tag, " latency"}, 64'(j), 64'(lat));
    chk({tag, " busy_off"}, 64'(busy), 64'd0);
    chk({tag, " hilo"}, {hi, lo}, exp);
    {hi_m, lo_m} = exp;
    @(negedge clk);
    chk({tag, " done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int dn;
    logic [31:0] ho, lo_o;
    rst = 1'b1; start = 1'b0; op = OP_NONE;
    a = '0; b = '0; flush = 1'b0;
    hi_m = '0; lo_m = '0;
    repeat (2) @(negedge clk);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    rst = 1'b0;

    run_op(OP_MULT, 32'hFFFF_FFFF, 32'd2, "mult");
    chk("mult_lit", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, "multu");
    chk("multu_lit", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, "div");
    chk("div_lit", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(OP_DIVU, 32'd7, 32'd2, "divu");
    chk("divu_lit", {hi, lo}, 64'h0000_0001_0000_0003);
    run_op(OP_DIVU, 32'h1234_5678, 32'd0, "divu0");
    chk("divu0_lit", {hi, lo}, 64'h1234_5678_FFFF_FFFF);
    run_op(OP_DIV, 32'hF000_0000, 32'd0, "div0");
    chk("div0_lit", {hi, lo}, 64'hF000_0000_FFFF_FFFF);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "divovf");
    chk("divovf_lit", {hi, lo}, 64'h0000_0000_8000_0000);

    // MTHI then MTLO back to back.
    @(negedge clk);
    start = 1'b1; op = OP_MTHI; a = 32'hAAAA_5555;
    @(negedge clk);
    chk("mthi_busy", 64'(busy), 64'd0);
    chk("mthi_done", 64'(done), 64'd0);
    op = OP_MTLO; a = 32'h1;
    @(negedge clk);
    start = 1'b0; op = OP_NONE;
    chk("mtlo_busy", 64'(busy), 64'd0);
    chk("mtlo_done", 64'(done), 64'd0);
    chk("mt_hilo", {hi, lo}, 64'hAAAA_5555_0000_0001);
    hi_m = 32'hAAAA_5555; lo_m = 32'h1;

    // Flush in IDLE suppresses a same-cycle start.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = OP_MTHI; a = 32'h0BAD_0BAD;
    @(negedge clk);
    op = OP_MULT; a = 32'd3; b = 32'd4;
    @(negedge clk);
    start = 1'b0; flush = 1'b0; op = OP_NONE;
    chk("idleflush_hi", 64'(hi), 64'(hi_m));
    chk("idleflush_busy", 64'(busy), 64'd0);

    // Start while busy is ignored; flush aborts mid-CALC.
    ho = hi_m; lo_o = lo_m;
    @(negedge clk);
    start = 1'b1; op = OP_MULT; a = 32'd5; b = 32'd6;
    @(negedge clk);
    start = 1'b0; op = OP_NONE;
    repeat (4) @(negedge clk);
    start = 1'b1; op = OP_DIV; a = 32'd100; b = 32'd3;
    @(negedge clk);
    start = 1'b0; op = OP_NONE;
    repeat (4) @(negedge clk);
    chk("abort_busy_pre", 64'(busy), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_hilo", {hi, lo}, {ho, lo_o});
    dn = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done || busy) dn++;
    end
    chk("abort_quiet", 64'(dn), 64'd0);
    chk("abort_hilo2", {hi, lo}, {ho, lo_o});

    // Asynchronous reset mid-CALC.
    @(negedge clk);
    start = 1'b1; op = OP_MULTU; a = 32'd7; b = 32'd9;
    @(negedge clk);
    start = 1'b0; op = OP_NONE;
    repeat (8) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    hi_m = '0; lo_m = '0;
    run_op(OP_MULTU, 32'd3, 32'd5, "post_rst");
    chk("post_rst_lit", {hi, lo}, 64'd15);

    // Random ops against the model.
    for (int n = 0; n < 24; n++) begin
      logic [2:0]  ro;
      logic [31:0] ra, rb;
      ro = 3'($urandom_range(1, 4));
      ra = $urandom;
      if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      run_op(ro, ra, rb, $sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
